// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the
//             word-addressed PC and the IF/ID register. It handles hazard
//             stalls and ID-resolved branch/jump redirects by squashing the
//             wrong-path fetch. It also keeps a saturating retired-fetch
//             counter for debug.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int PC_WIDTH  = 7,
  parameter int RESET_PC  = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_offset,
  input  logic                 jump_valid,
  input  logic [25:0]          jump_index,
  input  logic [31:0]          instr_in,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic                 im_stall,
  output logic [31:0]          if_id_instr,
  output logic [PC_WIDTH-1:0]  if_id_pc_plus1,
  output logic                 if_id_valid,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam logic [PC_WIDTH-1:0]  c_reset_pc = RESET_PC[PC_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;

  logic [PC_WIDTH-1:0]  pc_q,    pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [PC_WIDTH-1:0]  pcp1_q,  pcp1_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic                 w_redirect;
  logic [PC_WIDTH-1:0]  w_pc_plus1;
  logic [PC_WIDTH-1:0]  w_branch_target;
  logic [PC_WIDTH-1:0]  w_jump_target;
  logic                 w_unused;

  // Targets are truncated to the PC width so wrap-around is implicit.
  assign w_pc_plus1      = pc_q + 1'b1;
  assign w_branch_target = pcp1_q + branch_offset[PC_WIDTH-1:0];
  assign w_jump_target   = jump_index[PC_WIDTH-1:0];
  assign w_redirect      = (branch_taken | jump_valid) & ~stall;

  // The upper offset/index bits are architecturally ignored.
  assign w_unused = ^{branch_offset[15:PC_WIDTH], jump_index[25:PC_WIDTH]};

  // The memory turns the wrong-path word into a NOP while a redirect is taken.
  assign im_stall = w_redirect;

  // Next-state selection: stall holds, branch beats jump, otherwise fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      if (branch_taken) begin
        pc_d    = w_branch_target;
        instr_d = 32'd0;
        pcp1_d  = '0;
        valid_d = 1'b0;
      end else if (jump_valid) begin
        pc_d    = w_jump_target;
        instr_d = 32'd0;
        pcp1_d  = '0;
        valid_d = 1'b0;
      end else begin
        pc_d    = w_pc_plus1;
        instr_d = instr_in;
        pcp1_d  = w_pc_plus1;
        valid_d = 1'b1;
        if (cnt_q != c_cnt_max) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // PC, IF/ID register and fetch counter; reset has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= c_reset_pc;
      instr_q <= 32'd0;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out         = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus1 = pcp1_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. Directed scenarios followed
//             by random stall/branch/jump/reset traffic, compared against an
//             integer reference model of the fetch rules. A second instance
//             with a 4-bit counter exercises counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'd0;
  logic        jump_valid = 1'b0;
  logic [25:0] jump_index = 26'd0;

  logic [31:0] instr_in, instr_in2;
  logic [6:0]  pc_out, pc_out2, if_id_pc_plus1, if_id_pc_plus1_2;
  logic        im_stall, im_stall2, if_id_valid, if_id_valid2;
  logic [31:0] if_id_instr, if_id_instr2;
  logic [15:0] fetch_count;
  logic [3:0]  fetch_count2;

  logic [31:0] imem [0:127];

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers)
  int m_pc, m_pcp1, m_valid, m_cnt, m_cnt2;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  // Instruction memory: combinational read, NOP while im_stall is high.
  assign instr_in  = im_stall  ? 32'd0 : imem[pc_out];
  assign instr_in2 = im_stall2 ? 32'd0 : imem[pc_out2];

  fetch_stage #(.PC_WIDTH(7), .RESET_PC(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump_valid(jump_valid), .jump_index(jump_index),
    .instr_in(instr_in), .pc_out(pc_out), .im_stall(im_stall),
    .if_id_instr(if_id_instr), .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  fetch_stage #(.PC_WIDTH(7), .RESET_PC(0), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump_valid(jump_valid), .jump_index(jump_index),
    .instr_in(instr_in2), .pc_out(pc_out2), .im_stall(im_stall2),
    .if_id_instr(if_id_instr2), .if_id_pc_plus1(if_id_pc_plus1_2),
    .if_id_valid(if_id_valid2), .fetch_count(fetch_count2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check im_stall before the edge, advance the
  // model at the edge and compare every output just after it.
  task automatic step(input logic rst, input logic st, input logic bt,
                      input logic [15:0] off, input logic jv, input logic [25:0] ji);
    int tgt;
    reset = rst; stall = st; branch_taken = bt; branch_offset = off;
    jump_valid = jv; jump_index = ji;
    #2;
    chk("im_stall", {63'd0, im_stall}, {63'd0, (bt | jv) & ~st});
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_instr = 32'd0; m_pcp1 = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (st) begin
      // everything holds
    end else if (bt || jv) begin
      if (bt) begin
        tgt = m_pcp1 + int'($signed(off));
        m_pc = ((tgt % 128) + 128) % 128;
      end else begin
        m_pc = int'(ji) % 128;
      end
      m_instr = 32'd0; m_pcp1 = 0; m_valid = 0;
    end else begin
      m_instr = imem[m_pc];
      m_pc    = (m_pc + 1) % 128;
      m_pcp1  = m_pc;
      m_valid = 1;
      m_cnt   = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
      m_cnt2  = (m_cnt2 < 15)    ? m_cnt2 + 1 : 15;
    end
    #1;
    chk("pc_out",      64'(pc_out),         64'(m_pc));
    chk("if_id_instr", 64'(if_id_instr),    64'(m_instr));
    chk("if_id_pcp1",  64'(if_id_pc_plus1), 64'(m_pcp1));
    chk("if_id_valid", 64'(if_id_valid),    64'(m_valid));
    chk("fetch_count", 64'(fetch_count),    64'(m_cnt));
    chk("sat_count",   64'(fetch_count2),   64'(m_cnt2));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = $urandom;
    m_pc = 0; m_instr = 32'd0; m_pcp1 = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);

    // Free run A,B,C,D
    run(4);
    chk("first4_instr", 64'(if_id_instr), 64'(imem[3]));
    chk("first4_cnt",   64'(fetch_count), 64'd4);

    // Reach if_id_pc_plus1 = 13, then branch by -7 -> 6
    run(9);
    chk("pcp1_13", 64'(if_id_pc_plus1), 64'd13);
    step(1'b0, 1'b0, 1'b1, 16'hFFF9, 1'b0, 26'd0);
    chk("branch_pc6", 64'(pc_out), 64'd6);
    run(1);
    chk("branch_imem6", 64'(if_id_instr), 64'(imem[6]));

    // Branch and jump together: branch wins. Then jump alone to 40.
    run(6); // pcp1 = 13 again
    step(1'b0, 1'b0, 1'b1, 16'hFFF9, 1'b1, 26'd40);
    chk("br_over_jmp", 64'(pc_out), 64'd6);
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'h3FFFF28); // upper bits ignored -> 40
    chk("jump_pc40", 64'(pc_out), 64'd40);
    run(2);

    // PC wrap 126 -> 127 -> 0
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'd126);
    run(2);
    chk("wrap_pcp1_0", 64'(if_id_pc_plus1), 64'd0);
    run(2);

    // Stall three cycles with branch held, then redirect on release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 26'd0);
    step(1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 26'd0);
    run(9);

    // Reset during a stall
    step(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 26'd0);
    chk("rst_in_stall_cnt", 64'(fetch_count), 64'd0);

    // Enough fetches to saturate the 4-bit counter
    run(20);
    chk("sat_15", 64'(fetch_count2), 64'd15);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           16'($urandom),
           ($urandom_range(0, 7) == 0),
           26'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the 5-stage MIPS pipeline. Owns the program counter, drives the word address into the combinational instruction memory and captures the returned word into the IF/ID pipeline register. Handles hazard stalls and branch/jump redirects resolved in ID by squashing the wrong-path fetch. Keeps a retired-fetch counter for debug.

## Interface
Parameters:
- PC_WIDTH, 7, word-address width; matches the 128-entry instruction memory.
- RESET_PC, 0, PC value after reset.
- CNT_WIDTH, 16, width of the fetch counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; reset is synchronous and active-high.
- stall  in  1  hazard-unit hold: PC and IF/ID keep their values.
- branch_taken  in  1  ID-stage beq/bne resolved taken.
- branch_offset  in  16  signed word offset from the branch instruction (imm field).
- jump_valid  in  1  ID-stage j instruction.
- jump_index  in  26  j target field.
- instr_in  in  32  word returned by the instruction memory for pc_out.
- pc_out  out  PC_WIDTH  fetch address to the instruction memory (registered).
- im_stall  out  1  to the memory's stall input; forces a NOP onto instr_in.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc_plus1  out  PC_WIDTH  address of the fetched instruction + 1.
- if_id_valid  out  1  IF/ID holds a real (non-squashed) instruction.
- fetch_count  out  CNT_WIDTH  number of valid instructions loaded into IF/ID.

## Operation
- Addressing is word-based: sequential next PC = pc_out + 1, modulo 2^PC_WIDTH (127 -> 0 wraps silently).
- Branch target = if_id_pc_plus1 + branch_offset[PC_WIDTH-1:0], modulo 2^PC_WIDTH. Upper offset bits are ignored. Example: branch at 12, offset -7 -> 13 + (-7) = 6.
- Jump target = jump_index[PC_WIDTH-1:0]. Upper bits are ignored.
- redirect = (branch_taken | jump_valid) & ~stall.
- im_stall = redirect (combinational). The wrong-path word fetched this cycle therefore arrives as 32'd0.
- Per-edge priority, highest first:
  - reset: pc_out = RESET_PC; if_id_instr = 0; if_id_pc_plus1 = 0; if_id_valid = 0; fetch_count = 0.
  - stall: all registers hold. branch_taken and jump_valid are ignored; the hazard unit re-presents them after the stall.
  - branch_taken (wins over jump_valid if both are asserted): pc_out <= branch target; IF/ID loads 0 (NOP); if_id_pc_plus1 <= 0; if_id_valid <= 0.
  - jump_valid: same as branch, but with the jump target.
  - otherwise: pc_out <= pc_out + 1; if_id_instr <= instr_in; if_id_pc_plus1 <= pc_out + 1; if_id_valid <= 1.
- fetch_count increments by 1 on every edge that sets if_id_valid <= 1. It saturates at 2^CNT_WIDTH - 1 and does not wrap.
- Reset asserted mid-stall or mid-redirect: reset wins and takes effect at that edge.

## Timing
- Fetch latency: instr_in is combinational from pc_out in the same cycle. It appears on if_id_instr one edge after pc_out presents the address.
- First edge after reset deasserts: IF/ID gets IMEM[RESET_PC]; pc_out = RESET_PC + 1.
- Redirect penalty: one bubble. The redirect edge loads a NOP and the target PC. The next edge loads IMEM[target] with valid = 1.
- Stall of N cycles: pc_out, IF/ID and fetch_count are frozen for exactly N edges. Fetch resumes on the first edge with stall = 0.
- A redirect presented on the same cycle that stall drops is acted on at that edge.

## Test plan
- Reset then free-run with IMEM[0..3] = A, B, C, D -> after edges 1-4, if_id_instr = A, B, C, D; if_id_pc_plus1 = 1, 2, 3, 4; fetch_count = 4.
- PC wrap: run from pc_out = 126 -> 127 -> 0; if_id_pc_plus1 reads 127 then 0.
- Branch: with if_id_pc_plus1 = 13, assert branch_taken with offset 16'hFFF9 -> im_stall = 1 that cycle; next edge gives pc_out = 6, if_id_valid = 0, if_id_instr = 0; following edge gives if_id_instr = IMEM[6], valid = 1.
- Jump plus simultaneous branch: jump_index = 26'd40 with branch target 6 -> pc_out = 6 (branch priority). Jump alone -> pc_out = 40.
- Stall 3 cycles with branch_taken held high -> pc_out, IF/ID and fetch_count are unchanged for 3 edges and im_stall = 0. When stall drops, the redirect takes effect on that edge.
- Reset asserted during a stall with fetch_count = 9 -> next edge gives pc_out = 0, if_id_valid = 0, fetch_count = 0. Saturation: preload the count to 16'hFFFF; a valid fetch leaves it at 16'hFFFF.
